// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Key identity used for typematic repeat suppression
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } kb_key_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;

endpackage

// File: rtl/ps2_rx_link.sv
// PS/2 link receiver: synchronizers, ps2_clk glitch filter, frame FSM and
// inter-edge timeout. Emits a byte strobe or an error strobe (same-cycle, comb).
module ps2_rx_link
  import ps2_pkg::*;
#(
  parameter int unsigned FILT        = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_vld_c,
  output logic       err_c,
  output logic [7:0] rx_byte
);

  localparam int unsigned FCW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned TOW = 16;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall_c, timeout_c;
  rx_state_e      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  assign rx_byte = shift_q;

  // Stability filter: accept a new ps2_clk level after FILT equal samples
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_c     = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILT - 1)) begin
        filt_d = clk_s2_q;
        fall_c = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    timeout_c = (state_q != ST_IDLE) && !fall_c &&
                (to_cnt_q == TOW'(TIMEOUT_CYC - 1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall_c && !dat_s2_q)          state_d = ST_DATA;
      ST_DATA:   if (fall_c && bit_cnt_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (fall_c)                       state_d = ST_STOP;
      ST_STOP:   if (fall_c)                       state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
    if (timeout_c) state_d = ST_IDLE;
  end

  // FSM outputs and datapath updates
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = '0;
    byte_vld_c = 1'b0;
    err_c      = 1'b0;
    if (state_q != ST_IDLE) to_cnt_d = fall_c ? '0 : to_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: if (fall_c) begin
        if (!dat_s2_q) bit_cnt_d = 3'd0;
        else           err_c     = 1'b1;
      end
      ST_DATA: if (fall_c) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      ST_PARITY: if (fall_c) par_d = dat_s2_q;
      ST_STOP: if (fall_c) begin
        if (dat_s2_q && (^{shift_q, par_q})) byte_vld_c = 1'b1;
        else                                 err_c      = 1'b1;
      end
      default: ;
    endcase
    if (timeout_c) err_c = 1'b1;
  end

  // Synchronizer, filter and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

endmodule

// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard decoder: link receiver plus E0/F0 protocol layer with
// optional typematic-repeat suppression.
module ps2_kb_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILT        = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned NO_REPEAT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       NewKB,
  output logic [7:0] KB_DAT,
  output logic       KB_EXT,
  output logic       FRAME_ERR
);

  logic       byte_vld_c, err_c;
  logic [7:0] rx_byte;
  logic       new_kb_q, new_kb_d, frame_err_q, frame_err_d;
  logic [7:0] kb_dat_q, kb_dat_d;
  logic       kb_ext_q, kb_ext_d;
  logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  kb_key_t    held_q, held_d;
  logic       held_vld_q, held_vld_d;
  kb_key_t    cur_key_c;
  logic       match_c;

  ps2_rx_link #(
    .FILT        (FILT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_link (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_vld_c (byte_vld_c),
    .err_c      (err_c),
    .rx_byte    (rx_byte)
  );

  assign NewKB     = new_kb_q;
  assign KB_DAT    = kb_dat_q;
  assign KB_EXT    = kb_ext_q;
  assign FRAME_ERR = frame_err_q;

  // Protocol layer: prefix tracking, break handling, repeat suppression
  always_comb begin
    new_kb_d    = 1'b0;
    frame_err_d = 1'b0;
    kb_dat_d    = kb_dat_q;
    kb_ext_d    = kb_ext_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    cur_key_c   = '{ext: ext_pend_q, code: rx_byte};
    match_c     = (NO_REPEAT != 0) && held_vld_q && (held_q == cur_key_c);
    if (err_c) begin
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end else if (byte_vld_c) begin
      if (rx_byte == SC_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (brk_pend_q) begin
          if (match_c) held_vld_d = 1'b0;
        end else if (!match_c) begin
          new_kb_d   = 1'b1;
          kb_dat_d   = rx_byte;
          kb_ext_d   = ext_pend_q;
          held_d     = cur_key_c;
          held_vld_d = 1'b1;
        end
      end
    end
  end

  // Protocol and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_kb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      kb_dat_q    <= 8'h00;
      kb_ext_q    <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      held_q      <= '0;
      held_vld_q  <= 1'b0;
    end else begin
      new_kb_q    <= new_kb_d;
      frame_err_q <= frame_err_d;
      kb_dat_q    <= kb_dat_d;
      kb_ext_q    <= kb_ext_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
    end
  end

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Directed bench for ps2_kb_decoder: frames driven bit by bit, pulses counted
// by a negedge monitor, expectations hand-computed.
module tb_ps2_kb_decoder;
  import ps2_pkg::*;

  localparam int unsigned TO_CYC = 1000;
  localparam int unsigned HALF   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       NewKB, KB_EXT, FRAME_ERR;
  logic [7:0] KB_DAT;

  int vec_cnt = 0;
  int err_cnt = 0;
  int nkb_cnt = 0, ferr_cnt = 0, both_cnt = 0, chg_cnt = 0;
  int base_n, base_e;
  logic [7:0] prev_dat = 8'h00;
  logic       prev_ext = 1'b0;

  ps2_kb_decoder #(
    .FILT        (4),
    .TIMEOUT_CYC (TO_CYC),
    .NO_REPEAT   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .NewKB     (NewKB),
    .KB_DAT    (KB_DAT),
    .KB_EXT    (KB_EXT),
    .FRAME_ERR (FRAME_ERR)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles and illegal output behaviour
  always @(negedge clk) begin
    if (NewKB) nkb_cnt++;
    if (FRAME_ERR) ferr_cnt++;
    if (NewKB && FRAME_ERR) both_cnt++;
    if (reset && !NewKB && (KB_DAT !== prev_dat || KB_EXT !== prev_ext)) chg_cnt++;
    prev_dat = KB_DAT;
    prev_ext = KB_EXT;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic snap();
    base_n = nkb_cnt;
    base_e = ferr_cnt;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_val("rst_newkb", 32'(NewKB), 32'd0);
    check_val("rst_ferr", 32'(FRAME_ERR), 32'd0);
    check_val("rst_dat", 32'(KB_DAT), 32'h00);
    check_val("rst_ext", 32'(KB_EXT), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Plain make code
    snap();
    send_byte(SC_1, 1'b0);
    check_val("m16_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("m16_dat", 32'(KB_DAT), 32'h16);
    check_val("m16_ext", 32'(KB_EXT), 32'd0);

    // Extended make: no strobe after the prefix
    snap();
    send_byte(SC_EXT, 1'b0);
    check_val("e0_n", 32'(nkb_cnt - base_n), 32'd0);
    send_byte(SC_RIGHT, 1'b0);
    check_val("e074_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("e074_dat", 32'(KB_DAT), 32'h74);
    check_val("e074_ext", 32'(KB_EXT), 32'd1);

    // Break code: silent, outputs hold
    snap();
    send_byte(SC_BRK, 1'b0);
    send_byte(SC_1, 1'b0);
    check_val("brk_n", 32'(nkb_cnt - base_n), 32'd0);
    check_val("brk_e", 32'(ferr_cnt - base_e), 32'd0);
    check_val("brk_dat", 32'(KB_DAT), 32'h74);
    check_val("brk_ext", 32'(KB_EXT), 32'd1);

    // Bad parity then good frame
    snap();
    send_byte(SC_2, 1'b1);
    check_val("par_e", 32'(ferr_cnt - base_e), 32'd1);
    check_val("par_n", 32'(nkb_cnt - base_n), 32'd0);
    send_byte(SC_2, 1'b0);
    check_val("par_ok_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("par_ok_dat", 32'(KB_DAT), 32'h1E);
    check_val("par_ok_ext", 32'(KB_EXT), 32'd0);

    // Start error after E0 clears the prefix
    snap();
    send_byte(SC_EXT, 1'b0);
    send_bit(1'b1);
    repeat (60) @(negedge clk);
    check_val("start_e", 32'(ferr_cnt - base_e), 32'd1);
    send_byte(SC_UP, 1'b0);
    check_val("clr_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("clr_dat", 32'(KB_DAT), 32'h75);
    check_val("clr_ext", 32'(KB_EXT), 32'd0);

    // Typematic repeat suppressed
    snap();
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    check_val("rep_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("rep_dat", 32'(KB_DAT), 32'h74);

    // Extended break releases the held key
    snap();
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_BRK, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    check_val("xbrk_n", 32'(nkb_cnt - base_n), 32'd0);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    check_val("repress_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("repress_ext", 32'(KB_EXT), 32'd1);

    // Timeout on a partial frame
    snap();
    for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : SC_DOWN[i-1]);
    ps2_data = 1'b1;
    repeat (TO_CYC + 10) @(negedge clk);
    check_val("to_e", 32'(ferr_cnt - base_e), 32'd1);
    check_val("to_n", 32'(nkb_cnt - base_n), 32'd0);
    send_byte(SC_DOWN, 1'b0);
    check_val("to_ok_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("to_ok_dat", 32'(KB_DAT), 32'h72);

    // Reset mid-frame
    for (int i = 0; i < 4; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
    reset = 1'b0;
    #1;
    check_val("mrst_dat", 32'(KB_DAT), 32'h00);
    check_val("mrst_ext", 32'(KB_EXT), 32'd0);
    check_val("mrst_newkb", 32'(NewKB), 32'd0);
    check_val("mrst_ferr", 32'(FRAME_ERR), 32'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    snap();
    send_byte(SC_LEFT, 1'b0);
    check_val("post_rst_n", 32'(nkb_cnt - base_n), 32'd1);
    check_val("post_rst_e", 32'(ferr_cnt - base_e), 32'd0);
    check_val("post_rst_dat", 32'(KB_DAT), 32'h6B);
    check_val("post_rst_ext", 32'(KB_EXT), 32'd0);

    check_val("no_overlap", 32'(both_cnt), 32'd0);
    check_val("dat_stable", 32'(chg_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_kb_decoder.md
PS2_KB_DECODER -- requirements
Module: ps2_kb_decoder

Interface
REQ-001 Parameter FILT, default 4: number of consecutive equal samples needed to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT_CYC, default 50000: idle clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 Parameter NO_REPEAT, default 1: when 1, typematic repeats of a held key are suppressed.
REQ-004 Port clk, input, 1: system clock, all logic on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port ps2_clk, input, 1: PS/2 device clock, asynchronous to clk.
REQ-007 Port ps2_data, input, 1: PS/2 device data, asynchronous to clk.
REQ-008 Port NewKB, output, 1: one-cycle strobe, a new make code is valid on KB_DAT.
REQ-009 Port KB_DAT, output, 8: last accepted make code, held until the next strobe.
REQ-010 Port KB_EXT, output, 1: last accepted code was E0-prefixed, held with KB_DAT.
REQ-011 Port FRAME_ERR, output, 1: one-cycle strobe on a parity, start or stop error, or on timeout.

Function
REQ-012 Sampling: ps2_clk and ps2_data pass through 2-flop synchronizers; ps2_clk also passes through the FILT-sample stability filter.
REQ-013 Edge: a falling edge is a filtered ps2_clk 1->0 transition; ps2_data is sampled in that same cycle.
REQ-014 Link FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on an edge with data=0, go to DATA and clear the bit counter. On an edge with data=1, pulse FRAME_ERR and stay in IDLE.
REQ-016 DATA: shift 8 bits in LSB first, 3-bit counter; after bit 7, go to PARITY.
REQ-017 PARITY: capture the bit; parity is good when XOR of the 8 data bits and the parity bit equals 1 (odd parity). Go to STOP.
REQ-018 STOP: on the edge, require data=1 and good parity; otherwise pulse FRAME_ERR. Return to IDLE in either case.
REQ-019 Timeout: in any state other than IDLE, a 16-bit counter resets on each edge; reaching TIMEOUT_CYC pulses FRAME_ERR, forces IDLE and discards the partial byte.
REQ-020 Protocol layer, byte E0: set ext_pend, no strobe.
REQ-021 Protocol layer, byte F0: set brk_pend, no strobe.
REQ-022 Protocol layer, any other byte with brk_pend=1: break code. No strobe. Clear both pend flags. If NO_REPEAT=1 and the byte plus ext_pend match the held-key register, clear the held key.
REQ-023 Protocol layer, any other byte with brk_pend=0: make code. Clear both pend flags.
- If NO_REPEAT=1 and the byte plus ext_pend equal the held key: no strobe.
- Otherwise: NewKB=1 for exactly one cycle, KB_DAT=byte, KB_EXT=ext_pend, and the held key is updated.
REQ-024 Latency: NewKB asserts in the cycle after the stop-bit edge is detected.
REQ-025 Any FRAME_ERR clears ext_pend and brk_pend; the held key is kept.
REQ-026 NewKB and FRAME_ERR are never asserted in the same cycle.
REQ-027 KB_DAT and KB_EXT change only in a NewKB cycle.

Reset
REQ-028 reset=0 asynchronously sets:
- FSM to IDLE
- counters to 0
- shift register to 0x00
- pend flags to 0
- held key to invalid
- synchronizer and filter to 1
- NewKB=0, FRAME_ERR=0, KB_DAT=0x00, KB_EXT=0
REQ-029 A reset in mid-frame discards the partial frame; the first full frame after release decodes correctly.

Structure
REQ-030 Shared package ps2_pkg holds the FSM state enum and the constants SC_EXT=0xE0, SC_BRK=0xF0, SC_RIGHT=0x74, SC_LEFT=0x6B, SC_UP=0x75, SC_DOWN=0x72, SC_1=0x16, SC_2=0x1E.
REQ-031 One sub-module, ps2_rx_link, implements the synchronizer, filter, link FSM and timeout, and outputs a byte strobe plus an error strobe. The protocol layer stays in ps2_kb_decoder.

Verification
REQ-032 Frame 0x16 with good parity -> one NewKB pulse, KB_DAT=0x16, KB_EXT=0.
REQ-033 Frames E0, 74 -> one NewKB pulse, KB_DAT=0x74, KB_EXT=1; no strobe after the E0 frame.
REQ-034 Frames F0, 16 -> no NewKB, no FRAME_ERR; KB_DAT keeps its previous value.
REQ-035 Frame 0x1E with the parity bit inverted -> one FRAME_ERR pulse, no NewKB; a following good 0x1E -> NewKB, KB_DAT=0x1E.
REQ-036 NO_REPEAT=1:
- Frames E0 74, E0 74 -> one NewKB only.
- Then E0 F0 74 followed by E0 74 -> a second NewKB.
REQ-037 Five bits of a frame, then ps2_clk held high for TIMEOUT_CYC+10 cycles -> one FRAME_ERR. A following good 0x72 frame -> NewKB, KB_DAT=0x72. Reset asserted mid-frame -> all outputs 0 immediately.
